// File: rtl/tqv_gpio_pkg.sv
// Shared register map, interrupt mode encodings and the per-pin event decoder
// used by the GPIO block.
package tqv_gpio_pkg;

    localparam logic [2:0] REG_OUT      = 3'd0;
    localparam logic [2:0] REG_IN       = 3'd1;
    localparam logic [2:0] REG_OUT_SEL  = 3'd2;
    localparam logic [2:0] REG_IRQ_EN   = 3'd3;
    localparam logic [2:0] REG_IRQ_MODE = 3'd4;
    localparam logic [2:0] REG_IRQ_PEND = 3'd5;

    localparam logic [1:0] MODE_RISE  = 2'b00;
    localparam logic [1:0] MODE_FALL  = 2'b01;
    localparam logic [1:0] MODE_BOTH  = 2'b10;
    localparam logic [1:0] MODE_LEVEL = 2'b11;

    localparam logic [31:0] READ_UNMAPPED = 32'hFFFF_FFFF;

    // Event seen on one pin given its mode, the previous and the current sample.
    function automatic logic pin_event(input logic [1:0] mode, input logic prev, input logic cur);
        logic ev;
        case (mode)
            MODE_RISE: ev = ~prev & cur;
            MODE_FALL: ev = prev & ~cur;
            MODE_BOTH: ev = prev ^ cur;
            default:   ev = cur;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/tqv_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs; all stages clear to 0
// while reset is held.
module tqv_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/tqv_gpio.sv
// GPIO peripheral: output register with per-pin alternate-function select,
// synchronised inputs and edge/level interrupts with write-1-to-clear pending.
module tqv_gpio
    import tqv_gpio_pkg::*;
#(
    parameter int                  NUM_PINS    = 8,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [NUM_PINS-1:0] OUT_SEL_RST = {NUM_PINS{1'b0}}
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [2:0]          reg_addr,
    input  logic                sel,
    input  logic [1:0]          write_n,
    input  logic [1:0]          read_n,
    input  logic [31:0]         data_in,
    output logic [31:0]         data_out,
    input  logic [NUM_PINS-1:0] pin_in,
    input  logic [NUM_PINS-1:0] alt_in,
    output logic [NUM_PINS-1:0] pin_out,
    output logic                irq
);

    logic [NUM_PINS-1:0]   out_q, out_d;
    logic [NUM_PINS-1:0]   out_sel_q, out_sel_d;
    logic [NUM_PINS-1:0]   irq_en_q, irq_en_d;
    logic [2*NUM_PINS-1:0] irq_mode_q, irq_mode_d;
    logic [NUM_PINS-1:0]   irq_pend_q, irq_pend_d;
    logic [NUM_PINS-1:0]   prev_q;
    logic [NUM_PINS-1:0]   sync_in_w;
    logic [NUM_PINS-1:0]   pin_event_w;
    logic [NUM_PINS-1:0]   pend_clr_w;
    logic                  wr_en_w;
    logic                  unused_ok;

    tqv_sync #(
        .WIDTH (NUM_PINS),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rstn(rstn),
        .d_i (pin_in),
        .q_o (sync_in_w)
    );

    // Reads are side-effect free, so read_n and the unused upper write bits are ignored.
    assign unused_ok = ^{read_n, data_in};

    assign wr_en_w = sel && (write_n != 2'b11);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin
            assign pin_event_w[gi] = pin_event(irq_mode_q[2*gi +: 2], prev_q[gi], sync_in_w[gi]);
            assign pin_out[gi]     = out_sel_q[gi] ? out_q[gi] : alt_in[gi];
        end
    endgenerate

    always_comb begin
        out_d      = out_q;
        out_sel_d  = out_sel_q;
        irq_en_d   = irq_en_q;
        irq_mode_d = irq_mode_q;
        pend_clr_w = '0;
        if (wr_en_w) begin
            case (reg_addr)
                REG_OUT:      out_d      = data_in[NUM_PINS-1:0];
                REG_OUT_SEL:  out_sel_d  = data_in[NUM_PINS-1:0];
                REG_IRQ_EN:   irq_en_d   = data_in[NUM_PINS-1:0];
                REG_IRQ_MODE: irq_mode_d = data_in[2*NUM_PINS-1:0];
                REG_IRQ_PEND: pend_clr_w = data_in[NUM_PINS-1:0];
                default:      ;
            endcase
        end
        // A new event outranks a simultaneous clear so it is never lost.
        irq_pend_d = (irq_pend_q & ~pend_clr_w) | (pin_event_w & irq_en_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q      <= '0;
            out_sel_q  <= OUT_SEL_RST;
            irq_en_q   <= '0;
            irq_mode_q <= '0;
            irq_pend_q <= '0;
            prev_q     <= '0;
        end else begin
            out_q      <= out_d;
            out_sel_q  <= out_sel_d;
            irq_en_q   <= irq_en_d;
            irq_mode_q <= irq_mode_d;
            irq_pend_q <= irq_pend_d;
            prev_q     <= sync_in_w;
        end
    end

    always_comb begin
        data_out = READ_UNMAPPED;
        if (sel) begin
            case (reg_addr)
                REG_OUT:      data_out = 32'(out_q);
                REG_IN:       data_out = 32'(sync_in_w);
                REG_OUT_SEL:  data_out = 32'(out_sel_q);
                REG_IRQ_EN:   data_out = 32'(irq_en_q);
                REG_IRQ_MODE: data_out = 32'(irq_mode_q);
                REG_IRQ_PEND: data_out = 32'(irq_pend_q);
                default:      data_out = READ_UNMAPPED;
            endcase
        end
    end

    assign irq = |(irq_pend_q & irq_en_q);

endmodule

// File: tb/tb_tqv_gpio.sv
// Bench for tqv_gpio: an 8-pin/2-stage and a 16-pin/3-stage instance share the
// bus; expected values are queued when stimulus is applied and popped on sampling.
module tb_tqv_gpio;
    import tqv_gpio_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  reg_addr;
    logic [1:0]  write_n;
    logic [1:0]  read_n;
    logic [31:0] data_in;
    logic        sel8, sel16;
    logic [31:0] data_out8, data_out16;
    logic [7:0]  pin_in8, alt_in8, pin_out8;
    logic [15:0] pin_in16, alt_in16, pin_out16;
    logic        irq8, irq16;

    always #10 clk = ~clk;

    tqv_gpio #(.NUM_PINS(8)) dut8 (
        .clk(clk), .rstn(rstn), .reg_addr(reg_addr), .sel(sel8),
        .write_n(write_n), .read_n(read_n), .data_in(data_in), .data_out(data_out8),
        .pin_in(pin_in8), .alt_in(alt_in8), .pin_out(pin_out8), .irq(irq8)
    );

    tqv_gpio #(.NUM_PINS(16), .SYNC_STAGES(3)) dut16 (
        .clk(clk), .rstn(rstn), .reg_addr(reg_addr), .sel(sel16),
        .write_n(write_n), .read_n(read_n), .data_in(data_in), .data_out(data_out16),
        .pin_in(pin_in16), .alt_in(alt_in16), .pin_out(pin_out16), .irq(irq16)
    );

    typedef struct {
        string       tag;
        logic [31:0] value;
    } sb_item_t;

    sb_item_t sb_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag   = tag;
        it.value = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        sb_item_t it;
        if (sb_q.size() == 0) begin
            $display("FAIL sb_empty: observation with no expectation queued");
            $fatal(1);
        end
        it = sb_q.pop_front();
        check_eq(it.tag, obs, it.value);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        sb_push(tag, exp);
        sb_pop(obs);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus write, cycling through the three "write" encodings of write_n.
    task automatic wr(input bit big, input logic [2:0] addr, input logic [31:0] d);
        reg_addr = addr;
        data_in  = d;
        write_n  = 2'(wr_cnt % 3);
        wr_cnt++;
        if (big) sel16 = 1'b1; else sel8 = 1'b1;
        @(posedge clk);
        #1;
        sel8    = 1'b0;
        sel16   = 1'b0;
        write_n = 2'b11;
    endtask

    task automatic rd(input bit big, input logic [2:0] addr, input string tag, input logic [31:0] exp);
        sb_push(tag, exp);
        reg_addr = addr;
        read_n   = 2'b10;
        if (big) sel16 = 1'b1; else sel8 = 1'b1;
        #1;
        sb_pop(big ? data_out16 : data_out8);
        sel8   = 1'b0;
        sel16  = 1'b0;
        read_n = 2'b11;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstn     = 1'b0;
        reg_addr = '0;
        write_n  = 2'b11;
        read_n   = 2'b11;
        data_in  = '0;
        sel8     = 1'b0;
        sel16    = 1'b0;
        pin_in8  = '0;
        alt_in8  = 8'h3C;
        pin_in16 = '0;
        alt_in16 = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Reset state
        #1;
        chk("rst_pin_out", 32'(pin_out8), 32'h3C);
        chk("rst_irq", 32'(irq8), 32'h0);
        reg_addr = REG_OUT;
        #1;
        chk("sel0_read", data_out8, 32'hFFFF_FFFF);
        tick(1);
        rd(0, REG_OUT, "rst_out", 32'h0);
        rd(0, REG_OUT_SEL, "rst_out_sel", 32'h0);
        rd(0, REG_IRQ_EN, "rst_irq_en", 32'h0);
        tick(1);
        rd(0, REG_IRQ_MODE, "rst_irq_mode", 32'h0);
        rd(0, REG_IRQ_PEND, "rst_irq_pend", 32'h0);
        tick(1);

        // Register mux and pin_out select
        wr(0, REG_OUT, 32'hA5);
        wr(0, REG_OUT_SEL, 32'h0F);
        alt_in8 = 8'hFF;
        #1;
        chk("pin_out_mux", 32'(pin_out8), 32'hF5);
        rd(0, 3'd6, "unmapped6", 32'hFFFF_FFFF);
        rd(0, 3'd7, "unmapped7", 32'hFFFF_FFFF);
        rd(0, REG_OUT, "out_a5", 32'hA5);
        tick(1);
        wr(0, REG_OUT, 32'hFFFF_FF12);
        rd(0, REG_OUT, "out_high_bits", 32'h12);

        // Input synchroniser latency and read-only IN
        pin_in8 = 8'h3C;
        tick(1);
        rd(0, REG_IN, "in_after1", 32'h0);
        tick(1);
        rd(0, REG_IN, "in_after2", 32'h3C);
        wr(0, REG_IN, 32'hFF);
        rd(0, REG_IN, "in_ro", 32'h3C);
        wr(0, 3'd6, 32'h0);
        rd(0, REG_OUT_SEL, "unmapped_wr", 32'h0F);
        rd(0, REG_OUT, "out_kept", 32'h12);

        // Rising edge interrupt on pin 3
        pin_in8 = 8'h00;
        tick(3);
        wr(0, REG_IRQ_EN, 32'h08);
        pin_in8[3] = 1'b1;
        tick(2);
        rd(0, REG_IRQ_PEND, "rise_early", 32'h0);
        chk("rise_irq_early", 32'(irq8), 32'h0);
        tick(1);
        rd(0, REG_IRQ_PEND, "rise_pend", 32'h08);
        chk("rise_irq", 32'(irq8), 32'h1);
        wr(0, REG_IRQ_PEND, 32'h08);
        chk("w1c_irq", 32'(irq8), 32'h0);
        rd(0, REG_IRQ_PEND, "w1c_pend", 32'h0);

        // Level mode on pin 0
        wr(0, REG_IRQ_MODE, 32'h3);
        wr(0, REG_IRQ_EN, 32'h01);
        pin_in8[0] = 1'b1;
        tick(3);
        rd(0, REG_IRQ_PEND, "level_pend", 32'h01);
        wr(0, REG_IRQ_PEND, 32'h01);
        rd(0, REG_IRQ_PEND, "level_w1c_held", 32'h01);
        chk("level_irq", 32'(irq8), 32'h1);
        pin_in8[0] = 1'b0;
        tick(3);
        wr(0, REG_IRQ_PEND, 32'h01);
        rd(0, REG_IRQ_PEND, "level_cleared", 32'h0);

        // Set/clear collision, both-edges mode on pin 2
        wr(0, REG_IRQ_MODE, 32'h20);
        wr(0, REG_IRQ_EN, 32'h04);
        pin_in8[2] = 1'b1;
        tick(2);
        wr(0, REG_IRQ_PEND, 32'h04);
        rd(0, REG_IRQ_PEND, "collision", 32'h04);
        rd(0, REG_IRQ_MODE, "mode_rb", 32'h20);
        wr(0, REG_IRQ_EN, 32'h0);
        rd(0, REG_IRQ_PEND, "pend_kept_en0", 32'h04);
        chk("irq_en0", 32'(irq8), 32'h0);

        // Asynchronous reset mid-cycle with everything pending
        wr(0, REG_IRQ_MODE, 32'hFFFF);
        wr(0, REG_IRQ_EN, 32'hFF);
        pin_in8 = 8'hFF;
        tick(3);
        rd(0, REG_IRQ_PEND, "pend_all", 32'hFF);
        alt_in8 = 8'h5A;
        #1;
        chk("pin_out_pre_rst", 32'(pin_out8), 32'h52);
        chk("irq_pre_rst", 32'(irq8), 32'h1);
        rstn = 1'b0;
        #1;
        chk("rst_async_irq", 32'(irq8), 32'h0);
        chk("rst_async_pin_out", 32'(pin_out8), 32'h5A);
        rd(0, REG_IRQ_PEND, "rst_async_pend", 32'h0);
        tick(2);
        rstn = 1'b1;
        tick(5);
        rd(0, REG_IRQ_PEND, "post_rst_pend", 32'h0);
        chk("post_rst_irq", 32'(irq8), 32'h0);

        // 16 pins, 3 synchroniser stages
        wr(1, REG_IRQ_MODE, 32'hAAAA_AAAA);
        rd(1, REG_IRQ_MODE, "mode16_rb", 32'hAAAA_AAAA);
        pin_in16[15] = 1'b1;
        tick(4);
        rd(1, REG_IN, "in16", 32'h8000);
        wr(1, REG_IRQ_EN, 32'h8000);
        pin_in16[15] = 1'b0;
        tick(3);
        rd(1, REG_IRQ_PEND, "fall16_early", 32'h0);
        tick(1);
        rd(1, REG_IRQ_PEND, "fall16_pend", 32'h8000);
        chk("fall16_irq", 32'(irq16), 32'h1);
        chk("pin_out16", 32'(pin_out16), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
